// File: rtl/fp_addsub_pipe_if.sv
// Operand-side and result-side valid/ready bundle for fp_addsub_pipe.
// Parameters must match those of the fp_addsub_pipe instance that uses it.
interface fp_addsub_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             sub;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     s;
    logic [TAG_W-1:0] out_tag;
    logic             overflow;
    logic             underflow;
    logic             invalid;

    modport master (
        output in_valid, a, b, sub, in_tag, out_ready,
        input  in_ready, out_valid, s, out_tag, overflow, underflow, invalid
    );

    modport slave (
        input  in_valid, a, b, sub, in_tag, out_ready,
        output in_ready, out_valid, s, out_tag, overflow, underflow, invalid
    );
endinterface

// File: rtl/fp_addsub_pipe.sv
// Pipelined floating-point adder/subtractor (unpack/align, add/normalize, round/pack), RNE rounding.
// Define FP_ADDSUB_OUTREG_EN to add a fourth output register stage (latency 4 instead of 3).
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input logic           clk,
    input logic           rst,
    fp_addsub_pipe_if.slave io
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int SW  = MAN_W + 4;
    localparam int LZW = $clog2(SW);
    localparam int XW  = EXP_W + LZW + 2;
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic en;
    logic last_valid;

    assign en          = io.out_ready || !last_valid;
    assign io.in_ready = en;

    logic             sign_a, sign_b;
    logic [EXP_W-1:0] exp_a, exp_b, exp_diff;
    logic [MAN_W-1:0] frac_a, frac_b;
    logic             zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, a_big;
    logic [SW-1:0]    big_sig, small_sig, small_aligned, shift_mask;
    logic             spec_c, inv_c;
    logic [W-1:0]     spec_val_c;

    // Unpack, classify, order by magnitude and align the smaller significand with G/R/S.
    always_comb begin
        sign_a = io.a[W-1];
        sign_b = io.b[W-1] ^ io.sub;
        exp_a  = io.a[W-2:MAN_W];
        exp_b  = io.b[W-2:MAN_W];
        frac_a = io.a[MAN_W-1:0];
        frac_b = io.b[MAN_W-1:0];
        zero_a = (exp_a == '0);
        zero_b = (exp_b == '0);
        inf_a  = (exp_a == EXP_ONES) && (frac_a == '0);
        inf_b  = (exp_b == EXP_ONES) && (frac_b == '0);
        nan_a  = (exp_a == EXP_ONES) && (frac_a != '0);
        nan_b  = (exp_b == EXP_ONES) && (frac_b != '0);
        a_big  = (io.a[W-2:0] >= io.b[W-2:0]);

        big_sig   = a_big ? {1'b1, frac_a, 3'b000} : {1'b1, frac_b, 3'b000};
        small_sig = a_big ? {1'b1, frac_b, 3'b000} : {1'b1, frac_a, 3'b000};
        exp_diff  = a_big ? (exp_a - exp_b) : (exp_b - exp_a);

        shift_mask    = '0;
        small_aligned = '0;
        if (32'(exp_diff) >= 32'(MAN_W + 3)) begin
            small_aligned = {{(SW-1){1'b0}}, 1'b1};
        end else begin
            shift_mask       = ~({SW{1'b1}} << exp_diff);
            small_aligned    = small_sig >> exp_diff;
            small_aligned[0] = small_aligned[0] | (|(small_sig & shift_mask));
        end

        spec_c     = 1'b1;
        inv_c      = 1'b0;
        spec_val_c = '0;
        if (nan_a || nan_b) begin
            spec_val_c = QNAN;
            inv_c      = 1'b1;
        end else if (inf_a && inf_b && (sign_a != sign_b)) begin
            spec_val_c = QNAN;
            inv_c      = 1'b1;
        end else if (inf_a) begin
            spec_val_c = {sign_a, EXP_ONES, {MAN_W{1'b0}}};
        end else if (inf_b) begin
            spec_val_c = {sign_b, EXP_ONES, {MAN_W{1'b0}}};
        end else if (zero_a && zero_b) begin
            spec_val_c = {sign_a & sign_b, {(W-1){1'b0}}};
        end else if (zero_a) begin
            spec_val_c = {sign_b, io.b[W-2:0]};
        end else if (zero_b) begin
            spec_val_c = io.a;
        end else begin
            spec_c = 1'b0;
        end
    end

    logic             s1_valid, s1_special, s1_invalid, s1_sign, s1_eff_sub;
    logic [W-1:0]     s1_spec_val;
    logic [EXP_W-1:0] s1_exp;
    logic [SW-1:0]    s1_big_sig, s1_small_sig;
    logic [TAG_W-1:0] s1_tag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid     <= 1'b0;
            s1_special   <= 1'b0;
            s1_invalid   <= 1'b0;
            s1_sign      <= 1'b0;
            s1_eff_sub   <= 1'b0;
            s1_spec_val  <= '0;
            s1_exp       <= '0;
            s1_big_sig   <= '0;
            s1_small_sig <= '0;
            s1_tag       <= '0;
        end else if (en) begin
            s1_valid     <= io.in_valid;
            s1_special   <= spec_c;
            s1_invalid   <= inv_c;
            s1_sign      <= a_big ? sign_a : sign_b;
            s1_eff_sub   <= sign_a ^ sign_b;
            s1_spec_val  <= spec_val_c;
            s1_exp       <= a_big ? exp_a : exp_b;
            s1_big_sig   <= big_sig;
            s1_small_sig <= small_aligned;
            s1_tag       <= io.in_tag;
        end
    end

    logic [SW:0]    sum;
    logic [LZW-1:0] lzc;
    logic [SW-1:0]  norm_sig;
    logic [XW-1:0]  norm_exp;

    // Magnitude add/subtract; the swap guarantees a non-negative difference.
    always_comb begin
        sum = s1_eff_sub ? ({1'b0, s1_big_sig} - {1'b0, s1_small_sig})
                         : ({1'b0, s1_big_sig} + {1'b0, s1_small_sig});
        lzc = '0;
        for (int i = 0; i < SW; i++) begin
            if (sum[i]) lzc = LZW'(SW - 1 - i);
        end
        if (sum[SW]) begin
            norm_sig    = sum[SW:1];
            norm_sig[0] = sum[1] | sum[0];
            norm_exp    = XW'(s1_exp) + XW'(1);
        end else begin
            norm_sig = sum[SW-1:0] << lzc;
            norm_exp = XW'(s1_exp) - XW'(lzc);
        end
    end

    logic             s2_valid, s2_special, s2_invalid, s2_sign;
    logic [W-1:0]     s2_spec_val;
    logic [XW-1:0]    s2_exp;
    logic [SW-1:0]    s2_sig;
    logic [TAG_W-1:0] s2_tag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid    <= 1'b0;
            s2_special  <= 1'b0;
            s2_invalid  <= 1'b0;
            s2_sign     <= 1'b0;
            s2_spec_val <= '0;
            s2_exp      <= '0;
            s2_sig      <= '0;
            s2_tag      <= '0;
        end else if (en) begin
            s2_valid    <= s1_valid;
            s2_special  <= s1_special;
            s2_invalid  <= s1_invalid;
            s2_sign     <= s1_sign;
            s2_spec_val <= s1_spec_val;
            s2_exp      <= norm_exp;
            s2_sig      <= norm_sig;
            s2_tag      <= s1_tag;
        end
    end

    logic             round_up;
    logic [MAN_W:0]   frac_r;
    logic [XW-1:0]    exp_r;
    logic [W-1:0]     res_c;
    logic             ovf_c, unf_c, inv3_c;

    // A normalized nonzero significand always has its top bit set, so a clear top bit means exact zero.
    always_comb begin
        round_up = s2_sig[2] & (s2_sig[1] | s2_sig[0] | s2_sig[3]);
        frac_r   = {1'b0, s2_sig[SW-2:3]} + (MAN_W+1)'(round_up);
        exp_r    = s2_exp + XW'(frac_r[MAN_W]);
        ovf_c    = 1'b0;
        unf_c    = 1'b0;
        inv3_c   = 1'b0;
        res_c    = '0;
        if (s2_special) begin
            res_c  = s2_spec_val;
            inv3_c = s2_invalid;
        end else if (!s2_sig[SW-1]) begin
            res_c = '0;
        end else if (s2_exp[XW-1] || (s2_exp == '0)) begin
            res_c = {s2_sign, {(W-1){1'b0}}};
            unf_c = 1'b1;
        end else if (exp_r >= XW'(EXP_ONES)) begin
            res_c = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
            ovf_c = 1'b1;
        end else begin
            res_c = {s2_sign, exp_r[EXP_W-1:0], frac_r[MAN_W-1:0]};
        end
    end

    logic             s3_valid, s3_ovf, s3_unf, s3_inv;
    logic [W-1:0]     s3_s;
    logic [TAG_W-1:0] s3_tag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_valid <= 1'b0;
            s3_ovf   <= 1'b0;
            s3_unf   <= 1'b0;
            s3_inv   <= 1'b0;
            s3_s     <= '0;
            s3_tag   <= '0;
        end else if (en) begin
            s3_valid <= s2_valid;
            s3_ovf   <= ovf_c;
            s3_unf   <= unf_c;
            s3_inv   <= inv3_c;
            s3_s     <= res_c;
            s3_tag   <= s2_tag;
        end
    end

`ifdef FP_ADDSUB_OUTREG_EN
    logic             s4_valid, s4_ovf, s4_unf, s4_inv;
    logic [W-1:0]     s4_s;
    logic [TAG_W-1:0] s4_tag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s4_valid <= 1'b0;
            s4_ovf   <= 1'b0;
            s4_unf   <= 1'b0;
            s4_inv   <= 1'b0;
            s4_s     <= '0;
            s4_tag   <= '0;
        end else if (en) begin
            s4_valid <= s3_valid;
            s4_ovf   <= s3_ovf;
            s4_unf   <= s3_unf;
            s4_inv   <= s3_inv;
            s4_s     <= s3_s;
            s4_tag   <= s3_tag;
        end
    end

    assign last_valid   = s4_valid;
    assign io.s         = s4_s;
    assign io.out_tag   = s4_tag;
    assign io.overflow  = s4_ovf;
    assign io.underflow = s4_unf;
    assign io.invalid   = s4_inv;
`else
    assign last_valid   = s3_valid;
    assign io.s         = s3_s;
    assign io.out_tag   = s3_tag;
    assign io.overflow  = s3_ovf;
    assign io.underflow = s3_unf;
    assign io.invalid   = s3_inv;
`endif

    assign io.out_valid = last_valid;
endmodule

// File: doc/fp_addsub_pipe.md
# fp_addsub_pipe

Parametrised, pipelined IEEE-754-style floating-point adder/subtractor with a valid/ready handshake on both sides. It is the next-generation version of the team's single-precision combinational adder. Exponent and mantissa widths are configurable, rounding is round-to-nearest-even, special operands get full handling, and it reports overflow, underflow and invalid flags. It sits between operand-issue logic and the FP result writeback in the datapath.

## Interface
Parameters:
- EXP_W, 8, exponent field width (≥3)
- MAN_W, 23, stored fraction width (≥2); word width W = 1+EXP_W+MAN_W
- TAG_W, 4, opaque sideband tag carried with each operation

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts operands this cycle
- a  in  W  operand A {sign, exp, frac}
- b  in  W  operand B
- sub  in  1  0: A+B, 1: A−B (B sign inverted before processing)
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- s  out  W  result
- out_tag  out  TAG_W  tag of this result
- overflow  out  1  result rounded beyond max finite, returned as ±inf
- underflow  out  1  nonzero result below min normal, flushed to ±0
- invalid  out  1  inf−inf or NaN operand, result is canonical NaN

## Operation
- Input fire = in_valid && in_ready. Output fire = out_valid && out_ready.
- Stage 1 (unpack/align):
  - Classify each operand as zero (exp==0; subnormals flush to zero), inf, NaN or normal.
  - Insert the hidden 1.
  - Put the larger-magnitude operand in the "big" slot. Compare exponent first, then fraction.
  - Right-shift the small significand by the exponent difference, keeping guard, round and sticky bits. Shifts ≥ MAN_W+3 leave only sticky.
- Stage 2 (add/normalize):
  - Add significands for effective add, subtract them for effective subtract. Result is never negative because of the swap.
  - Normalize: on carry-out, right-shift 1 and exp+1. Otherwise left-shift by the leading-zero count and decrease exp by the same amount. Sticky is preserved.
- Stage 3 (round/pack):
  - Round to nearest even using G/R/S. A rounding carry bumps exp.
  - Result sign is the sign of the big operand.
  - An exact-zero result is +0, except (−0)+(−0) and (−0)−(+0), which give −0.
- Special cases, in priority order:
  - Any NaN input → canonical NaN {0, all-ones, 1 followed by zeros}, invalid=1.
  - inf ± inf with opposite effective signs → canonical NaN, invalid=1.
  - One inf → that inf (sign after sub inversion).
  - A zero operand → the other operand returned exactly (after sub inversion).
- Exponent range checks:
  - Biased exp > 2^EXP_W−2 after rounding → {sign, all-ones, 0}, overflow=1.
  - Biased exp < 1 before rounding with nonzero significand → {sign, 0, 0}, underflow=1.
- Flags are per-result and valid only with out_valid.

## Timing
- Latency is 3 cycles from input fire to out_valid. With FP_ADDSUB_OUTREG_EN it is 4.
- Throughput is one operation per cycle with no bubbles.
- Single global stall: en = out_ready || !out_valid. All stages advance only on en. in_ready = en (combinational from out_ready).
- While stalled, s, out_tag and all flags hold stable. out_valid stays high until output fire.
- Internal stage valids advance with en, so bubbles propagate. No reordering: results come out in input order.
- Reset (async, any time, including mid-operation):
  - in_ready=1 after deassertion.
  - All stage valids=0, so in-flight operations are discarded.
  - out_valid=0, s=0, out_tag=0, overflow=0, underflow=0, invalid=0.
- in_valid low with in_ready high inserts a bubble. Operand values during a bubble are don't-care.

## Configuration
- FP_ADDSUB_OUTREG_EN defined:
  - Adds a fourth register stage after pack. Latency is 4.
  - The added register participates in the same global en.
  - s, out_tag and all flags come directly from flops.
- Not defined:
  - Latency is 3. Outputs come from the stage-3 register.
- Function, rounding, flags and handshake are identical in both builds.

## Test plan
All values use default parameters.
- 0x3F800000 + 0x3F800000 (sub=0) → s=0x40000000, all flags 0, out_valid exactly 3 cycles after fire (4 with macro).
- 0x3F800000 − 0x3F800000 → 0x00000000. 0x80000000 + 0x80000000 → 0x80000000.
- Rounding:
  - 0x3F800000 + 0x33800000 (exact tie) → 0x3F800000.
  - 0x3F800001 + 0x33800000 → 0x3F800002.
- Special cases:
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, overflow=1.
  - 0x7F800000 − 0x7F800000 → 0x7FC00000, invalid=1.
  - 0x00800001 − 0x00800000 → 0x00000000, underflow=1.
- Backpressure:
  - Issue 8 back-to-back operations with tags 0–7 while out_ready toggles pseudo-randomly.
  - in_ready must track en.
  - All 8 results must arrive in tag order, with none lost or duplicated.
  - Outputs must hold stable while stalled.
- Reset mid-operation:
  - Assert rst asynchronously with 3 operations in flight → out_valid=0 and all outputs 0 immediately.
  - After deassertion, a new operation 0x40400000 + 0x3F800000 → 0x40800000 with correct latency.
